mem_byte_sequencer: RTL
=======================

# mem_byte_sequencer

Multi-cycle access controller between the core's load/store unit and the byte-wide data memory (one byte per access, combinational read, write on posedge). It accepts one LB/LH/LW/LBU/LHU/SB/SH/SW request at a time and issues 1, 2 or 4 consecutive byte accesses, little-endian. For loads it assembles and sign- or zero-extends the result. It holds `busy` so the core stalls while the request is in progress.

## Interface
- `MEM_BYTES`, default 128: size of the byte memory; valid addresses are 0..MEM_BYTES-1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request strobe; sampled only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V funct3. 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU (4 and 5 are loads only).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data.
- `busy` out 1: high while in ACCESS.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: qualifies `done`; the request was rejected.
- `rdata` out 32: load result; holds its value until the next `done`.
- `mem_read` out 1: to memory `mem_read`.
- `mem_write` out 1: to memory `mem_write`.
- `mem_addr` out 32: to memory `endereco`.
- `mem_wdata` out 32: to memory `write_data`; only bits [7:0] are meaningful.
- `mem_rdata` in 32: from memory `read_data`; only bits [7:0] are used.

## Operation
- Three states: IDLE, ACCESS, DONE. Internal registers: `base` (32 bits), `op` (write flag and funct3), `cnt` (2 bits), `N` (byte count 1/2/4), `buf` (32 bits).
- **IDLE**
  - If `req_valid` is high, latch `base`, `op` and `req_wdata`, and set `cnt` = 0.
  - If the request is legal, go to ACCESS; if illegal, go to DONE with the error flag set.
  - If `req_valid` is low, stay in IDLE.
- **Illegal request**, any of:
  - `funct3` is 3, 6 or 7.
  - A store with `funct3` 4 or 5.
  - H/HU with `req_addr[0]` = 1.
  - W with `req_addr[1:0]` ≠ 0.
  - `req_addr` + N − 1 ≥ MEM_BYTES.
  - An illegal request makes no memory access.
- **ACCESS**, one byte per cycle:
  - Drive `mem_addr` = `base` + `cnt`.
  - Load:
    - Drive `mem_read` = 1.
    - On the edge, capture `mem_rdata[7:0]` into `buf[8*cnt+7 : 8*cnt]`.
  - Store:
    - Drive `mem_write` = 1 and `mem_wdata` = {24'b0, wdata byte `cnt`}.
    - The memory writes on the same edge.
  - If `cnt` == N − 1, go to DONE; otherwise increment `cnt`.
- **DONE**
  - `done` = 1.
  - `err` = the error flag.
  - Go unconditionally to IDLE. `req_valid` is ignored in DONE and in ACCESS.
- **rdata**, updated on the edge entering DONE, only for successful loads:
  - B: sign-extend `buf[7]`.
  - BU: zero-extend `buf[7:0]`.
  - H: sign-extend `buf[15]`.
  - HU: zero-extend `buf[15:0]`.
  - W: `buf`.
  - Stores and errors leave `rdata` unchanged.
- Outside ACCESS, `mem_read`, `mem_write`, `mem_addr` and `mem_wdata` are all 0.
- Width rules:
  - The address sum is computed in 32 bits.
  - The range check is done without wrap-around: an overflowing sum counts as out of range.

## Timing
- **Reset:**
  - State goes to IDLE; `cnt`, `buf` and the flags are cleared.
  - `busy`, `done`, `err`, `mem_read` and `mem_write` are 0; `rdata`, `mem_addr` and `mem_wdata` are 32'h0.
- **Reset during ACCESS:** the request is abandoned and no `done` is issued. Bytes already stored stay in memory (a partial store is permitted).
- **Latency:** request accepted at edge E0.
  - ACCESS occupies cycles E0..E0+N (`busy` high for N cycles).
  - `done` is high in the cycle after edge E0+N.
  - IDLE again after edge E0+N+1.
  - Total request-to-request spacing is N + 2 cycles.
- **Error latency:** `done` and `err` are high in the cycle after E0; `busy` never rises.
- **Pipelining:** none. The earliest next acceptance is the edge at the end of the DONE cycle, with the sequencer back in IDLE.
- **Output timing:**
  - Memory-side outputs and `busy` are combinational from state/`cnt` and registers only; they are glitch-free with respect to request inputs.
  - `done`, `err` and `rdata` are registered.

## Test plan
- **SW then LW:** SW addr 8, data 32'hDEADBEEF.
  - Memory bytes 8..11 become EF, BE, AD, DE.
  - `busy` is high 4 cycles; `done` comes 5 cycles after accept.
  - LW addr 8 gives `rdata` = 32'hDEADBEEF with `err` = 0.
- **Byte and halfword extension:** SB addr 3, data 8'h80.
  - LB addr 3 gives 32'hFFFFFF80; LBU gives 32'h00000080.
  - SH addr 6, data 16'h8001; LH gives 32'hFFFF8001 and LHU gives 32'h00008001, with `busy` high 2 cycles each.
- **Misalignment:** LW addr 2, SH addr 5, and LH addr 1.
  - Each gives a `done` + `err` pulse the cycle after accept.
  - `mem_write` and `mem_read` never rise, memory is unchanged, and `rdata` is unchanged.
- **Range and illegal funct3:**
  - LW addr 124 is accepted (last word); LW addr 125 is rejected (misaligned).
  - LB addr 128 sets `err`.
  - Store with funct3 4 sets `err`; load with funct3 3 sets `err`.
- **Ignored requests:** hold `req_valid` high with changing addresses during ACCESS and DONE. Only the first request is executed, and the next one is accepted in IDLE after `done`.
- **Mid-operation reset:** assert `rst` in the second ACCESS cycle of SW addr 16, data 32'h11223344.
  - Outputs are 0 the next cycle and no `done` is issued.
  - Byte 16 = 44 and byte 17 = 00.
  - A following LB addr 16 completes normally.

Source files
------------

// File: rtl/mem_byte_sequencer.sv
// Load/store sequencer that moves 1, 2 or 4 bytes little-endian over a byte-wide memory port,
// assembling and extending load results and rejecting illegal or out-of-range requests.
module mem_byte_sequencer #(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] base_q;
  logic        wr_q;
  logic [2:0]  f3_q;
  logic [1:0]  cnt_q;
  logic [2:0]  n_q;
  logic [31:0] buf_q, buf_d;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q, rdata_ext;

  logic [2:0]  req_n;
  logic        f3_bad, store_bad, align_bad, range_bad, req_illegal;
  logic [32:0] end_addr;
  logic        last;

  logic unused_rdata;
  assign unused_rdata = ^mem_rdata[31:8];

  // Request legality; the end address is 33 bits wide so a wrapping sum reads as out of range.
  always_comb begin
    req_n  = 3'd1;
    f3_bad = 1'b0;
    case (req_funct3)
      3'd0, 3'd4: req_n = 3'd1;
      3'd1, 3'd5: req_n = 3'd2;
      3'd2:       req_n = 3'd4;
      default:    f3_bad = 1'b1;
    endcase
    store_bad   = req_write && req_funct3[2];
    align_bad   = ((req_n == 3'd2) && req_addr[0]) ||
                  ((req_n == 3'd4) && (req_addr[1:0] != 2'b00));
    end_addr    = {1'b0, req_addr} + {30'b0, req_n - 3'd1};
    range_bad   = end_addr >= 33'(MEM_BYTES);
    req_illegal = f3_bad || store_bad || align_bad || range_bad;
  end

  assign last = ({1'b0, cnt_q} == (n_q - 3'd1));

  always_comb begin
    buf_d = buf_q;
    buf_d[{cnt_q, 3'b000} +: 8] = mem_rdata[7:0];
  end

  always_comb begin
    case (f3_q)
      3'd0:    rdata_ext = {{24{buf_d[7]}}, buf_d[7:0]};
      3'd4:    rdata_ext = {24'b0, buf_d[7:0]};
      3'd1:    rdata_ext = {{16{buf_d[15]}}, buf_d[15:0]};
      3'd5:    rdata_ext = {16'b0, buf_d[15:0]};
      default: rdata_ext = buf_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = req_illegal ? StDone : StAccess;
        end
      end
      StAccess: begin
        if (last) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q  <= 32'h0;
      wr_q    <= 1'b0;
      f3_q    <= 3'd0;
      cnt_q   <= 2'd0;
      n_q     <= 3'd0;
      buf_q   <= 32'h0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            base_q  <= req_addr;
            wr_q    <= req_write;
            f3_q    <= req_funct3;
            wdata_q <= req_wdata;
            cnt_q   <= 2'd0;
            n_q     <= req_n;
            err_q   <= req_illegal;
          end
        end
        StAccess: begin
          if (!wr_q) begin
            buf_q <= buf_d;
          end
          if (last) begin
            if (!wr_q) begin
              rdata_q <= rdata_ext;
            end
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory strobes are also held off while rst is high so an abandoned store writes no more bytes.
  always_comb begin
    busy      = (state_q == StAccess);
    done      = (state_q == StDone);
    err       = done && err_q;
    rdata     = rdata_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if ((state_q == StAccess) && !rst) begin
      mem_read  = !wr_q;
      mem_write = wr_q;
      mem_addr  = base_q + {30'b0, cnt_q};
      mem_wdata = wr_q ? {24'b0, wdata_q[{cnt_q, 3'b000} +: 8]} : 32'h0;
    end
  end

endmodule
